// File: rtl/pa_dtu_trig_pkg.sv
// rtl/pa_dtu_trig_pkg.sv - shared definitions for the DTU trigger match array
//
// Purpose: mcontrol (type 2) field positions, match encodings, CSR addresses,
// privilege codes, halt FSM states and the mcontrol read-back packer.
// Ports: none (package).

package pa_dtu_trig_pkg;

  localparam logic [11:0] CSR_TSELECT = 12'h7a0;
  localparam logic [11:0] CSR_TDATA1  = 12'h7a1;
  localparam logic [11:0] CSR_TDATA2  = 12'h7a2;

  localparam int MC_TYPE_LSB    = 28;
  localparam int MC_DMODE       = 27;
  localparam int MC_MASKMAX_LSB = 21;
  localparam int MC_HIT         = 20;
  localparam int MC_ACTION_LSB  = 12;
  localparam int MC_CHAIN       = 11;
  localparam int MC_MATCH_LSB   = 7;
  localparam int MC_M           = 6;
  localparam int MC_U           = 3;
  localparam int MC_EXE         = 2;
  localparam int MC_STORE       = 1;
  localparam int MC_LOAD        = 0;

  localparam logic [3:0] MC_TYPE    = 4'd2;
  localparam logic [5:0] MC_MASKMAX = 6'd31;

  localparam logic [3:0] CAUSE_TRIGGER = 4'd2;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  typedef enum logic [1:0] {
    MATCH_EQ    = 2'd0,
    MATCH_NAPOT = 2'd1,
    MATCH_GE    = 2'd2,
    MATCH_LT    = 2'd3
  } match_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HALT_REQ = 2'd1,
    ST_DONE     = 2'd2
  } halt_state_e;

  // Only the writable mcontrol state; type and maskmax are constants.
  // action is kept as one bit because only 0 and 1 are legal.
  typedef struct packed {
    logic   dmode;
    logic   hit;
    logic   action;
    logic   chain;
    match_e match;
    logic   m;
    logic   u;
    logic   execute;
    logic   store;
    logic   load;
  } mcontrol_t;

  function automatic logic [31:0] mc_pack(input mcontrol_t mc);
    logic [31:0] r;
    r = '0;
    r[MC_TYPE_LSB +: 4]    = MC_TYPE;
    r[MC_DMODE]            = mc.dmode;
    r[MC_MASKMAX_LSB +: 6] = MC_MASKMAX;
    r[MC_HIT]              = mc.hit;
    r[MC_ACTION_LSB +: 4]  = {3'b000, mc.action};
    r[MC_CHAIN]            = mc.chain;
    r[MC_MATCH_LSB +: 4]   = {2'b00, mc.match};
    r[MC_M]                = mc.m;
    r[MC_U]                = mc.u;
    r[MC_EXE]              = mc.execute;
    r[MC_STORE]            = mc.store;
    r[MC_LOAD]             = mc.load;
    return r;
  endfunction

endpackage

// File: rtl/pa_dtu_trig_cmp.sv
// rtl/pa_dtu_trig_cmp.sv - one mcontrol trigger: registers, write legalisation, comparators
//
// Purpose: holds one trigger's tdata1/tdata2, legalises CSR writes, and
// evaluates the execute (two lanes) and load/store address matches including
// the chain term from the next-higher trigger.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   wr_tdata1/wr_tdata2  CSR write strobes already qualified by tselect
//   wdata                CSR write data
//   dbgon, priv          debug-mode flag and current privilege
//   retire_hit           a retiring instruction reports a hit on this trigger
//   exe_vld0/1, exe_addr0/1, ldst_vld, ldst_addr, ldst_type  access inputs
//   chain_in0/1/ls       fire of trigger i+1 on the same access
//   fire0/1/ls           this trigger fires on lane 0/1 or the LSU port
//   action               1 = enter debug on retirement
//   tdata1, tdata2       read-back values

module pa_dtu_trig_cmp
  import pa_dtu_trig_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter bit LAST   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_tdata1,
  input  logic              wr_tdata2,
  input  logic [31:0]       wdata,
  input  logic              dbgon,
  input  logic [1:0]        priv,
  input  logic              retire_hit,
  input  logic              exe_vld0,
  input  logic [ADDR_W-1:0] exe_addr0,
  input  logic              exe_vld1,
  input  logic [ADDR_W-1:0] exe_addr1,
  input  logic              ldst_vld,
  input  logic [ADDR_W-1:0] ldst_addr,
  input  logic [1:0]        ldst_type,
  input  logic              chain_in0,
  input  logic              chain_in1,
  input  logic              chain_in_ls,
  output logic              fire0,
  output logic              fire1,
  output logic              fire_ls,
  output logic              action,
  output logic [31:0]       tdata1,
  output logic [31:0]       tdata2
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  mcontrol_t         mc;
  mcontrol_t         mc_next;
  logic [ADDR_W-1:0] t2;
  logic              wr_ok;
  logic              priv_ok;
  logic              raw0, raw1, raw_ls;

  // NAPOT: the trailing ones plus the first zero above them are don't-care.
  // An all-ones tdata2 wraps ones+1 to zero, so every bit becomes don't-care.
  function automatic logic addr_cmp(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] t,
                                    input match_e            mode);
    logic [ADDR_W-1:0] ones;
    logic [ADDR_W-1:0] ign;
    ones = t & ~(t + ONE);
    ign  = ones | (ones + ONE);
    case (mode)
      MATCH_EQ:    addr_cmp = (a == t);
      MATCH_NAPOT: addr_cmp = (((a ^ t) & ~ign) == '0);
      MATCH_GE:    addr_cmp = (a >= t);
      default:     addr_cmp = (a < t);
    endcase
  endfunction

  // A trigger owned by debug mode is frozen outside debug mode.
  assign wr_ok = !(mc.dmode && !dbgon);

  always_comb begin
    mc_next         = '0;
    mc_next.dmode   = wdata[MC_DMODE] & dbgon;
    mc_next.hit     = wdata[MC_HIT];
    mc_next.action  = (wdata[MC_ACTION_LSB +: 4] == 4'd1) & mc_next.dmode;
    mc_next.chain   = LAST ? 1'b0 : wdata[MC_CHAIN];
    mc_next.match   = (wdata[MC_MATCH_LSB + 2 +: 2] == 2'b00) ?
                      match_e'(wdata[MC_MATCH_LSB +: 2]) : MATCH_EQ;
    mc_next.m       = wdata[MC_M];
    mc_next.u       = wdata[MC_U];
    mc_next.execute = wdata[MC_EXE];
    mc_next.store   = wdata[MC_STORE];
    mc_next.load    = wdata[MC_LOAD];
  end

  // The tdata1 write is placed after the retire update so it wins when both
  // land in the same cycle, hit bit included.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc <= '0;
      t2 <= '0;
    end else begin
      if (retire_hit) begin
        mc.hit <= 1'b1;
      end
      if (wr_tdata1 && wr_ok) begin
        mc <= mc_next;
      end
      if (wr_tdata2 && wr_ok) begin
        t2 <= wdata[ADDR_W-1:0];
      end
    end
  end

  assign priv_ok = ((priv == PRIV_M) && mc.m) || ((priv == PRIV_U) && mc.u);

  assign raw0 = exe_vld0 && mc.execute && priv_ok && !dbgon &&
                addr_cmp(exe_addr0, t2, mc.match);
  assign raw1 = exe_vld1 && mc.execute && priv_ok && !dbgon &&
                addr_cmp(exe_addr1, t2, mc.match);
  assign raw_ls = ldst_vld && ((mc.store && ldst_type[0]) || (mc.load && ldst_type[1])) &&
                  priv_ok && !dbgon && addr_cmp(ldst_addr, t2, mc.match);

  assign fire0   = raw0   && (!mc.chain || chain_in0);
  assign fire1   = raw1   && (!mc.chain || chain_in1);
  assign fire_ls = raw_ls && (!mc.chain || chain_in_ls);

  assign action = mc.action;
  assign tdata1 = mc_pack(mc);
  assign tdata2 = 32'(t2);

endmodule

// File: rtl/pa_dtu_trig_array.sv
// rtl/pa_dtu_trig_array.sv - parametrised DTU trigger match array with debug-halt handshake
//
// Purpose: NUM_TRIG mcontrol triggers behind tselect; matches two IFU execute
// lanes and the LSU port, reports lowest-index hits one cycle later, records
// retired hits and requests debug halt from RTU.
// Ports:
//   forever_cpuclk, cpurst                 clock, synchronous active-high reset
//   cp0_dtu_wreg/addr/wdata                CSR write port (7a0/7a1/7a2)
//   cp0_yy_priv_mode, rtu_yy_xx_dbgon      privilege, debug-mode flag
//   ifu_dtu_addr_vld0/1, ifu_dtu_exe_addr0/1   execute addresses
//   lsu_dtu_ldst_addr_vld/addr/type        load/store address
//   rtu_dtu_retire_vld/trig/idx            retirement with trigger hit
//   rtu_dtu_halt_ack                       RTU entered debug mode
//   tselect, tdata1, tdata2, tinfo         CSR read values
//   dtu_ifu_hit_vld0/1, dtu_ifu_hit_idx0/1 registered execute hits
//   dtu_lsu_hit_vld, dtu_lsu_hit_idx       registered load/store hit
//   pending_halt, dtu_cause                halt request and dcsr cause

module pa_dtu_trig_array
  import pa_dtu_trig_pkg::*;
#(
  parameter int NUM_TRIG = 4,
  parameter int IDX_W    = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              cp0_dtu_wreg,
  input  logic [11:0]       cp0_dtu_addr,
  input  logic [31:0]       cp0_dtu_wdata,
  input  logic [1:0]        cp0_yy_priv_mode,
  input  logic              rtu_yy_xx_dbgon,
  input  logic              ifu_dtu_addr_vld0,
  input  logic              ifu_dtu_addr_vld1,
  input  logic [ADDR_W-1:0] ifu_dtu_exe_addr0,
  input  logic [ADDR_W-1:0] ifu_dtu_exe_addr1,
  input  logic              lsu_dtu_ldst_addr_vld,
  input  logic [ADDR_W-1:0] lsu_dtu_ldst_addr,
  input  logic [1:0]        lsu_dtu_ldst_type,
  input  logic              rtu_dtu_retire_vld,
  input  logic              rtu_dtu_retire_trig,
  input  logic [IDX_W-1:0]  rtu_dtu_retire_idx,
  input  logic              rtu_dtu_halt_ack,
  output logic [31:0]       tselect,
  output logic [31:0]       tdata1,
  output logic [31:0]       tdata2,
  output logic [31:0]       tinfo,
  output logic              dtu_ifu_hit_vld0,
  output logic              dtu_ifu_hit_vld1,
  output logic [IDX_W-1:0]  dtu_ifu_hit_idx0,
  output logic [IDX_W-1:0]  dtu_ifu_hit_idx1,
  output logic              dtu_lsu_hit_vld,
  output logic [IDX_W-1:0]  dtu_lsu_hit_idx,
  output logic              pending_halt,
  output logic [3:0]        dtu_cause
);

  logic [IDX_W-1:0]    sel_q;
  logic                wr_tdata1, wr_tdata2;
  logic                retire_go;
  logic                retire_act;
  logic [NUM_TRIG-1:0] fire0, fire1, fire_ls, act;
  logic [31:0]         t1_rd [NUM_TRIG];
  logic [31:0]         t2_rd [NUM_TRIG];
  halt_state_e         state, state_n;
  logic [3:0]          cause_n;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_TRIG-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  assign wr_tdata1 = cp0_dtu_wreg && (cp0_dtu_addr == CSR_TDATA1);
  assign wr_tdata2 = cp0_dtu_wreg && (cp0_dtu_addr == CSR_TDATA2);
  assign retire_go = rtu_dtu_retire_vld && rtu_dtu_retire_trig;

  // tselect is WARL: out-of-range indices leave the current selection.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      sel_q <= '0;
    end else if (cp0_dtu_wreg && (cp0_dtu_addr == CSR_TSELECT) &&
                 (cp0_dtu_wdata < 32'(NUM_TRIG))) begin
      sel_q <= cp0_dtu_wdata[IDX_W-1:0];
    end
  end

  // Each trigger reads its chain input from the next trigger's own fire
  // signals, so the chain ripples downward from the highest index.
  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
    logic f0, f1, fls;
    logic c0, c1, cls;

    if (i == NUM_TRIG - 1) begin : g_tail
      assign c0  = 1'b0;
      assign c1  = 1'b0;
      assign cls = 1'b0;
    end else begin : g_link
      assign c0  = g_trig[i+1].f0;
      assign c1  = g_trig[i+1].f1;
      assign cls = g_trig[i+1].fls;
    end

    pa_dtu_trig_cmp #(
      .ADDR_W (ADDR_W),
      .LAST   (i == NUM_TRIG - 1)
    ) u_cmp (
      .clk         (forever_cpuclk),
      .rst         (cpurst),
      .wr_tdata1   (wr_tdata1 && (sel_q == IDX_W'(i))),
      .wr_tdata2   (wr_tdata2 && (sel_q == IDX_W'(i))),
      .wdata       (cp0_dtu_wdata),
      .dbgon       (rtu_yy_xx_dbgon),
      .priv        (cp0_yy_priv_mode),
      .retire_hit  (retire_go && (rtu_dtu_retire_idx == IDX_W'(i))),
      .exe_vld0    (ifu_dtu_addr_vld0),
      .exe_addr0   (ifu_dtu_exe_addr0),
      .exe_vld1    (ifu_dtu_addr_vld1),
      .exe_addr1   (ifu_dtu_exe_addr1),
      .ldst_vld    (lsu_dtu_ldst_addr_vld),
      .ldst_addr   (lsu_dtu_ldst_addr),
      .ldst_type   (lsu_dtu_ldst_type),
      .chain_in0   (c0),
      .chain_in1   (c1),
      .chain_in_ls (cls),
      .fire0       (f0),
      .fire1       (f1),
      .fire_ls     (fls),
      .action      (act[i]),
      .tdata1      (t1_rd[i]),
      .tdata2      (t2_rd[i])
    );

    assign fire0[i]   = f0;
    assign fire1[i]   = f1;
    assign fire_ls[i] = fls;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      dtu_ifu_hit_vld0 <= 1'b0;
      dtu_ifu_hit_vld1 <= 1'b0;
      dtu_lsu_hit_vld  <= 1'b0;
      dtu_ifu_hit_idx0 <= '0;
      dtu_ifu_hit_idx1 <= '0;
      dtu_lsu_hit_idx  <= '0;
    end else begin
      dtu_ifu_hit_vld0 <= |fire0;
      dtu_ifu_hit_vld1 <= |fire1;
      dtu_lsu_hit_vld  <= |fire_ls;
      dtu_ifu_hit_idx0 <= lowest_idx(fire0);
      dtu_ifu_hit_idx1 <= lowest_idx(fire1);
      dtu_lsu_hit_idx  <= lowest_idx(fire_ls);
    end
  end

  always_comb begin
    tdata1     = '0;
    tdata2     = '0;
    retire_act = 1'b0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (sel_q == IDX_W'(i)) begin
        tdata1 = t1_rd[i];
        tdata2 = t2_rd[i];
      end
      if (rtu_dtu_retire_idx == IDX_W'(i)) begin
        retire_act = act[i];
      end
    end
  end

  assign tselect = 32'(sel_q);
  assign tinfo   = 32'h4;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state     <= ST_IDLE;
      dtu_cause <= '0;
    end else begin
      state     <= state_n;
      dtu_cause <= cause_n;
    end
  end

  // Retire hits outside IDLE only set hit bits (done in the trigger slices).
  always_comb begin
    state_n      = state;
    cause_n      = dtu_cause;
    pending_halt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (retire_go && retire_act) begin
          state_n = ST_HALT_REQ;
          cause_n = CAUSE_TRIGGER;
        end
      end
      ST_HALT_REQ: begin
        pending_halt = 1'b1;
        if (rtu_dtu_halt_ack) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (!rtu_yy_xx_dbgon) begin
          state_n = ST_IDLE;
          cause_n = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cause_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pa_dtu_trig_array.sv
// tb/tb_pa_dtu_trig_array.sv - scoreboard bench for pa_dtu_trig_array
module tb_pa_dtu_trig_array;

  localparam int NUM_TRIG = 4;
  localparam int IDX_W    = 4;
  localparam int ADDR_W   = 32;

  localparam logic [11:0] A_SEL = 12'h7a0;
  localparam logic [11:0] A_T1  = 12'h7a1;
  localparam logic [11:0] A_T2  = 12'h7a2;
  // type = 2 in [31:28], maskmax = 31 in [26:21]
  localparam logic [31:0] RD_BASE = 32'h23E0_0000;

  logic              clk = 1'b0;
  logic              cpurst;
  logic              cp0_dtu_wreg;
  logic [11:0]       cp0_dtu_addr;
  logic [31:0]       cp0_dtu_wdata;
  logic [1:0]        cp0_yy_priv_mode;
  logic              rtu_yy_xx_dbgon;
  logic              vld0, vld1, ls_vld;
  logic [ADDR_W-1:0] addr0, addr1, ls_addr;
  logic [1:0]        ls_type;
  logic              retire_vld, retire_trig, halt_ack;
  logic [IDX_W-1:0]  retire_idx;
  logic [31:0]       tselect, tdata1, tdata2, tinfo;
  logic              hv0, hv1, hvl, pending_halt;
  logic [IDX_W-1:0]  hi0, hi1, hil;
  logic [3:0]        dtu_cause;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic v0; logic [3:0] i0;
    logic v1; logic [3:0] i1;
    logic vl; logic [3:0] il;
  } hit_t;

  hit_t exp_q[$];
  logic acc_d = 1'b0;

  always #5 clk = ~clk;

  pa_dtu_trig_array #(.NUM_TRIG(NUM_TRIG), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .forever_cpuclk        (clk),
    .cpurst                (cpurst),
    .cp0_dtu_wreg          (cp0_dtu_wreg),
    .cp0_dtu_addr          (cp0_dtu_addr),
    .cp0_dtu_wdata         (cp0_dtu_wdata),
    .cp0_yy_priv_mode      (cp0_yy_priv_mode),
    .rtu_yy_xx_dbgon       (rtu_yy_xx_dbgon),
    .ifu_dtu_addr_vld0     (vld0),
    .ifu_dtu_addr_vld1     (vld1),
    .ifu_dtu_exe_addr0     (addr0),
    .ifu_dtu_exe_addr1     (addr1),
    .lsu_dtu_ldst_addr_vld (ls_vld),
    .lsu_dtu_ldst_addr     (ls_addr),
    .lsu_dtu_ldst_type     (ls_type),
    .rtu_dtu_retire_vld    (retire_vld),
    .rtu_dtu_retire_trig   (retire_trig),
    .rtu_dtu_retire_idx    (retire_idx),
    .rtu_dtu_halt_ack      (halt_ack),
    .tselect               (tselect),
    .tdata1                (tdata1),
    .tdata2                (tdata2),
    .tinfo                 (tinfo),
    .dtu_ifu_hit_vld0      (hv0),
    .dtu_ifu_hit_vld1      (hv1),
    .dtu_ifu_hit_idx0      (hi0),
    .dtu_ifu_hit_idx1      (hi1),
    .dtu_lsu_hit_vld       (hvl),
    .dtu_lsu_hit_idx       (hil),
    .pending_halt          (pending_halt),
    .dtu_cause             (dtu_cause)
  );

  always @(posedge clk) acc_d <= vld0 | vld1 | ls_vld;

  // Monitor: one expected record per access cycle; idx only matters with vld.
  initial begin
    hit_t got, e;
    forever begin
      @(negedge clk);
      got = {hv0, hv0 ? hi0 : 4'h0, hv1, hv1 ? hi1 : 4'h0, hvl, hvl ? hil : 4'h0};
      if (acc_d) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL hit_unexpected_output got %h with empty scoreboard", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL hit_record got %h want %h at %0t", got, e, $time);
          end
        end
      end else if (hv0 | hv1 | hvl) begin
        checks++;
        errors++;
        $display("FAIL hit_without_access got %h want 0", got);
      end
    end
  end

  function automatic hit_t mk(input logic v0, input int i0, input logic v1, input int i1,
                              input logic vl, input int il);
    mk = {v0, 4'(i0), v1, 4'(i1), vl, 4'(il)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    cp0_dtu_wreg  = 1'b1;
    cp0_dtu_addr  = a;
    cp0_dtu_wdata = d;
    tick();
    cp0_dtu_wreg  = 1'b0;
  endtask

  task automatic access(input logic v0, input logic [31:0] a0, input logic v1,
                        input logic [31:0] a1, input logic vl, input logic [31:0] al,
                        input logic [1:0] ty, input hit_t e);
    vld0 = v0; addr0 = a0; vld1 = v1; addr1 = a1;
    ls_vld = vl; ls_addr = al; ls_type = ty;
    exp_q.push_back(e);
    tick();
    vld0 = 1'b0; vld1 = 1'b0; ls_vld = 1'b0;
  endtask

  task automatic retire(input int idx);
    retire_vld = 1'b1; retire_trig = 1'b1; retire_idx = IDX_W'(idx);
    tick();
    retire_vld = 1'b0; retire_trig = 1'b0;
  endtask

  initial begin
    cpurst = 1'b1; cp0_dtu_wreg = 1'b0; cp0_dtu_addr = '0; cp0_dtu_wdata = '0;
    cp0_yy_priv_mode = 2'b11; rtu_yy_xx_dbgon = 1'b0;
    vld0 = 1'b0; vld1 = 1'b0; ls_vld = 1'b0; addr0 = '0; addr1 = '0; ls_addr = '0; ls_type = '0;
    retire_vld = 1'b0; retire_trig = 1'b0; retire_idx = '0; halt_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cpurst = 1'b0;

    chk("rst_tselect", tselect, 32'h0);
    chk("rst_tdata1", tdata1, RD_BASE);
    chk("rst_tdata2", tdata2, 32'h0);
    chk("rst_tinfo", tinfo, 32'h4);
    chk("rst_hits", {29'h0, hv0, hv1, hvl}, 32'h0);
    chk("rst_halt_cause", {27'h0, pending_halt, dtu_cause}, 32'h0);

    // T0: execute, equal 0x8000_0100, M mode, action 0
    csr_wr(A_SEL, 0);
    csr_wr(A_T2, 32'h8000_0100);
    csr_wr(A_T1, 32'h0000_0044);
    chk("t0_tdata1", tdata1, RD_BASE | 32'h44);
    chk("t0_tdata2", tdata2, 32'h8000_0100);
    access(1, 32'h8000_0104, 1, 32'h8000_0100, 0, 0, 2'b00, mk(0, 0, 1, 0, 0, 0));
    access(1, 32'h8000_0100, 1, 32'h8000_00FC, 0, 0, 2'b00, mk(1, 0, 0, 0, 0, 0));
    cp0_yy_priv_mode = 2'b00;
    access(1, 32'h8000_0100, 1, 32'h8000_0100, 0, 0, 2'b00, mk(0, 0, 0, 0, 0, 0));
    cp0_yy_priv_mode = 2'b11;

    // T1: load >= 0x2000 chained to T2: load < 0x3000
    csr_wr(A_SEL, 1);
    csr_wr(A_T2, 32'h0000_2000);
    csr_wr(A_T1, 32'h0000_0941);
    chk("t1_tdata1", tdata1, RD_BASE | 32'h941);
    csr_wr(A_SEL, 2);
    csr_wr(A_T2, 32'h0000_3000);
    csr_wr(A_T1, 32'h0000_01C1);
    access(0, 0, 0, 0, 1, 32'h0000_2800, 2'b10, mk(0, 0, 0, 0, 1, 1));
    access(0, 0, 0, 0, 1, 32'h0000_3800, 2'b10, mk(0, 0, 0, 0, 0, 0));
    access(0, 0, 0, 0, 1, 32'h0000_2800, 2'b01, mk(0, 0, 0, 0, 0, 0));

    // T3: store NAPOT 0x10FF (0x1000..0x11FF); chain bit on last trigger reads 0
    csr_wr(A_SEL, 3);
    csr_wr(A_T2, 32'h0000_10FF);
    csr_wr(A_T1, 32'h0000_08C2);
    chk("t3_chain_tied", tdata1, RD_BASE | 32'hC2);
    access(0, 0, 0, 0, 1, 32'h0000_1000, 2'b01, mk(0, 0, 0, 0, 1, 3));
    access(0, 0, 0, 0, 1, 32'h0000_11FF, 2'b01, mk(0, 0, 0, 0, 1, 3));
    access(0, 0, 0, 0, 1, 32'h0000_1200, 2'b01, mk(0, 0, 0, 0, 0, 0));
    access(0, 0, 0, 0, 1, 32'h0000_0FFF, 2'b01, mk(0, 0, 0, 0, 0, 0));

    // WARL: out-of-range tselect; dmode/action/match legalisation
    csr_wr(A_SEL, NUM_TRIG);
    chk("warl_tselect", tselect, 32'd3);
    csr_wr(A_T1, 32'h0800_12C2);
    chk("warl_tdata1", tdata1, RD_BASE | 32'h42);

    // action 0 retire: hit bit only
    retire(1);
    chk("ret_a0_pending", {31'h0, pending_halt}, 32'h0);
    csr_wr(A_SEL, 1);
    chk("ret_a0_hitbit", tdata1, RD_BASE | 32'h0010_0941);

    // debug-owned T0 with action 1
    rtu_yy_xx_dbgon = 1'b1;
    csr_wr(A_SEL, 0);
    csr_wr(A_T1, 32'h0800_1004);
    chk("dmode_wr", tdata1, 32'h2BE0_1004);
    rtu_yy_xx_dbgon = 1'b0;
    csr_wr(A_T1, 32'h0000_0044);
    csr_wr(A_T2, 32'h0000_1234);
    chk("dmode_lock_t1", tdata1, 32'h2BE0_1004);
    chk("dmode_lock_t2", tdata2, 32'h8000_0100);
    retire(0);
    chk("halt_pending", {31'h0, pending_halt}, 32'h1);
    chk("halt_cause", {28'h0, dtu_cause}, 32'h2);
    chk("halt_hitbit", tdata1, 32'h2BF0_1004);
    tick();
    chk("halt_hold", {31'h0, pending_halt}, 32'h1);
    halt_ack = 1'b1; rtu_yy_xx_dbgon = 1'b1;
    tick();
    halt_ack = 1'b0;
    chk("ack_pending", {31'h0, pending_halt}, 32'h0);
    chk("done_cause", {28'h0, dtu_cause}, 32'h2);
    tick();
    chk("done_hold_cause", {28'h0, dtu_cause}, 32'h2);
    rtu_yy_xx_dbgon = 1'b0;
    tick();
    chk("idle_cause", {28'h0, dtu_cause}, 32'h0);

    // reset during HALT_REQ
    retire(0);
    chk("halt2_pending", {31'h0, pending_halt}, 32'h1);
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    chk("rst_mid_pending", {31'h0, pending_halt}, 32'h0);
    chk("rst_mid_cause", {28'h0, dtu_cause}, 32'h0);
    for (int n = 0; n < NUM_TRIG; n++) begin
      csr_wr(A_SEL, 32'(n));
      chk($sformatf("rst_mid_tdata1_%0d", n), tdata1, RD_BASE);
      chk($sformatf("rst_mid_tdata2_%0d", n), tdata2, 32'h0);
    end

    // CSR write and retire hit to the same trigger in one cycle: CSR wins
    csr_wr(A_SEL, 1);
    retire_vld = 1'b1; retire_trig = 1'b1; retire_idx = 4'd1;
    csr_wr(A_T1, 32'h0000_0941);
    retire_vld = 1'b0; retire_trig = 1'b0;
    chk("csr_beats_retire", tdata1, RD_BASE | 32'h941);

    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
